// File: rtl/crem_ctrl_pkg.sv
// Shared command codes, operand addresses and sequencer states
// for the command-response control block.
package crem_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OPA,
        ST_OPB,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_e;

endpackage

// File: rtl/crem_frame_timer.sv
// Inter-byte timeout counter: reloads on a byte, counts while a
// frame is open, flags expiry after TIMEOUT_CYC silent cycles.
module crem_frame_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic active,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (reload || !active) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            expire = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/crem_sys_ctrl.sv
// Command sequencer: RX frames -> register file / ALU -> TX bytes.
// Optional inter-byte timeout when FRAME_TIMEOUT_EN is defined.
module crem_sys_ctrl
    import crem_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int ALU_FUN_W   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_valid,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_valid,
    input  logic                  tx_busy,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [DATA_W-1:0]     rf_wr_data,
    output logic                  alu_en,
    output logic [ALU_FUN_W-1:0]  alu_fun,
    output logic                  clk_gate_en,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  cmd_err
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      rf_addr_q, rf_addr_d;
    logic                   rf_wr_en_q, rf_wr_en_d;
    logic                   rf_rd_en_q, rf_rd_en_d;
    logic [DATA_W-1:0]      rf_wr_data_q, rf_wr_data_d;
    logic                   alu_en_q, alu_en_d;
    logic [ALU_FUN_W-1:0]   alu_fun_q, alu_fun_d;
    logic                   cg_en_q, cg_en_d;
    logic [DATA_W-1:0]      tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]      tx_hi_q, tx_hi_d;
    logic                   single_q, single_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   tx_fire;
    logic                   tmo_expire;

    assign tx_fire = tx_valid_q && !tx_busy;

`ifdef FRAME_TIMEOUT_EN
    logic frame_open;
    assign frame_open = state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                        ST_OPA, ST_OPB, ST_ALU_FUN};

    crem_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .reload (rx_valid),
        .active (frame_open),
        .expire (tmo_expire)
    );
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign tmo_expire         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = alu_en_q;
        alu_fun_d    = alu_fun_q;
        cg_en_d      = cg_en_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        tx_hi_d      = tx_hi_q;
        single_d     = single_q;
        cmd_err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        DATA_W'(CMD_RF_WR):   state_d = ST_WR_ADDR;
                        DATA_W'(CMD_RF_RD):   state_d = ST_RD_ADDR;
                        DATA_W'(CMD_ALU_OP):  state_d = ST_OPA;
                        DATA_W'(CMD_ALU_NOP): state_d = ST_ALU_FUN;
                        default:              cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                cmd_err_d = rx_valid;
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    single_d   = 1'b1;
                    state_d    = ST_TX_LO;
                end
            end
            ST_OPA: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPA_ADDR);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_OPB;
                end
            end
            ST_OPB: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPB_ADDR);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (rx_valid) begin
                    alu_fun_d = rx_data[ALU_FUN_W-1:0];
                    alu_en_d  = 1'b1;
                    cg_en_d   = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                cmd_err_d = rx_valid;
                if (alu_valid) begin
                    alu_en_d   = 1'b0;
                    cg_en_d    = 1'b0;
                    tx_data_d  = alu_out[DATA_W-1:0];
                    tx_hi_d    = alu_out[2*DATA_W-1:DATA_W];
                    tx_valid_d = 1'b1;
                    single_d   = 1'b0;
                    state_d    = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                cmd_err_d = rx_valid;
                if (tx_fire) begin
                    if (single_q) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        tx_data_d = tx_hi_q;
                        state_d   = ST_TX_HI;
                    end
                end
            end
            ST_TX_HI: begin
                cmd_err_d = rx_valid;
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A silent open frame is abandoned; earlier writes stand.
        if (tmo_expire) begin
            state_d   = ST_IDLE;
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            cg_en_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_hi_q      <= '0;
            single_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            cg_en_q      <= cg_en_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_hi_q      <= tx_hi_d;
            single_q     <= single_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign rf_addr     = rf_addr_q;
    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_en    = rf_rd_en_q;
    assign rf_wr_data  = rf_wr_data_q;
    assign alu_en      = alu_en_q;
    assign alu_fun     = alu_fun_q;
    assign clk_gate_en = cg_en_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign cmd_err     = cmd_err_q;

endmodule
